pc_next_unit: RTL and testbench

//  Parametrised program-counter unit for the MIPS CPU fetch stage: holds the PC, selects next PC
//  (sequential / branch / jump / register-jump / exception), supports pipeline stall and a run/halt
//  FSM. Feeds instruction-memory address and PC+INC to the decode stage and link register path.

---
 rtl/pc_next_unit.sv | 147 ++++++++++++++
 tb/tb_pc_next_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Fetch-stage PC with run/halt FSM, next-PC priority mux and optional return-address stack (PC_RAS_EN).
// Latency 1: every control input takes effect on the next rising edge; stall holds the PC, exc overrides stall.
module pc_next_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'd100,
  parameter logic [31:0] EXC_VEC   = 32'h80,
  parameter int unsigned INC       = 4,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             stall,
  input  logic             exc,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             running,
  output logic             ras_underflow
);

  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_V   = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] INC_V   = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_M = ~WIDTH'(3);

  typedef enum logic {HALT, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             running_q;
  logic             uflow_q, uflow_d;
  logic             active;
  logic             push, pop;

  assign active   = (state_q == RUN) && run;
  assign pc_plus4 = pc_q + INC_V;
  assign pc       = pc_q;
  assign running  = running_q;

`ifdef PC_RAS_EN
  localparam int unsigned        PW      = $clog2(RAS_DEPTH);
  localparam logic [PW:0]        DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    top_idx;
  logic [PW:0]      cnt_q;

  // ptr_q is the next write slot; the newest entry sits just below it
  assign top_idx       = ptr_q - 1'b1;
  assign ras_underflow = uflow_q;
`else
  logic unused_ras;
  assign unused_ras    = call ^ ret;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    pc_d    = RST_V;
    push    = 1'b0;
    pop     = 1'b0;
    uflow_d = 1'b0;
    if (active) begin
      if (exc) begin
        pc_d = EXC_V;
      end else if (stall) begin
        pc_d = pc_q;
      end else if (jr) begin
`ifdef PC_RAS_EN
        if (ret && (cnt_q != '0)) begin
          pc_d = ras_q[top_idx] & ALIGN_M;
          pop  = 1'b1;
        end else begin
          pc_d    = jr_target & ALIGN_M;
          uflow_d = ret;
        end
`else
        pc_d = jr_target & ALIGN_M;
`endif
      end else if (jump) begin
        pc_d = jump_target & ALIGN_M;
        push = call;
      end else if (branch_taken) begin
        pc_d = branch_target & ALIGN_M;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HALT;
      pc_q      <= RST_V;
      running_q <= 1'b0;
      uflow_q   <= 1'b0;
`ifdef PC_RAS_EN
      cnt_q     <= '0;
      ptr_q     <= '0;
`endif
    end else begin
      pc_q    <= pc_d;
      uflow_q <= uflow_d;
      case (state_q)
        HALT: if (run) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: if (!run) begin
          state_q   <= HALT;
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= HALT;
          running_q <= 1'b0;
        end
      endcase
`ifdef PC_RAS_EN
      if (!active) begin
        cnt_q <= '0;
        ptr_q <= '0;
      end else if (push) begin
        // a full stack overwrites its oldest slot and the count saturates
        ras_q[ptr_q] <= pc_plus4;
        ptr_q        <= ptr_q + 1'b1;
        if (cnt_q != DEPTH_C) cnt_q <= cnt_q + 1'b1;
      end else if (pop) begin
        ptr_q <= top_idx;
        cnt_q <= cnt_q - 1'b1;
      end
`else
      if (push || pop) begin
        uflow_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a 32-bit instance for control paths, an 8-bit instance for wrap-around.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst, run, stall, exc, jr, jump, branch_taken, call, ret;
  logic [31:0] jr_target, jump_target, branch_target;
  logic [31:0] pc, pc_plus4;
  logic        running, ras_underflow;

  logic        rst8, run8, jump8;
  logic [7:0]  jump_target8;
  logic [7:0]  pc8, pc_plus4_8;
  logic        running8, ras_underflow8;
  logic [7:0]  zero8 = 8'h00;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk(clk), .rst(rst), .run(run), .stall(stall), .exc(exc),
    .jr(jr), .jr_target(jr_target), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .call(call), .ret(ret), .pc(pc), .pc_plus4(pc_plus4),
    .running(running), .ras_underflow(ras_underflow)
  );

  pc_next_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .run(run8), .stall(1'b0), .exc(1'b0),
    .jr(1'b0), .jr_target(zero8), .jump(jump8), .jump_target(jump_target8),
    .branch_taken(1'b0), .branch_target(zero8),
    .call(1'b0), .ret(1'b0), .pc(pc8), .pc_plus4(pc_plus4_8),
    .running(running8), .ras_underflow(ras_underflow8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; exc = 0; jr = 0; jump = 0; branch_taken = 0; call = 0; ret = 0;
    jr_target = '0; jump_target = '0; branch_target = '0;
  endtask

  task automatic goto(input logic [31:0] addr);
    jump = 1; jump_target = addr;
    tick();
    clear_ctl();
  endtask

  task automatic test_reset();
    rst = 1; run = 1;
    tick();
    rst = 0;
    n_chk++; if (pc !== 32'd100) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'd100); end
    n_chk++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got=%b exp=0", running); end
    n_chk++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_uflow got=%b exp=0", ras_underflow); end
    n_chk++; if (pc_plus4 !== 32'd104) begin n_fail++; $display("FAIL reset_plus4 got=%h exp=%h", pc_plus4, 32'd104); end
  endtask

  task automatic test_startup();
    logic [31:0] exp_seq [4];
    exp_seq = '{32'd100, 32'd104, 32'd108, 32'd112};
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (pc !== exp_seq[i]) begin n_fail++; $display("FAIL startup_pc[%0d] got=%h exp=%h", i, pc, exp_seq[i]); end
    end
    n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL startup_running got=%b exp=1", running); end
  endtask

  task automatic test_jump_branch();
    goto(32'd200);
    n_chk++; if (pc !== 32'd200) begin n_fail++; $display("FAIL jb_goto got=%h exp=%h", pc, 32'd200); end
    branch_taken = 1; branch_target = 32'h3F0; jump = 1; jump_target = 32'h500;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'h500) begin n_fail++; $display("FAIL jump_over_branch got=%h exp=%h", pc, 32'h500); end
    branch_taken = 1; branch_target = 32'h3F2;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'h3F0) begin n_fail++; $display("FAIL branch_align got=%h exp=%h", pc, 32'h3F0); end
    tick();
    n_chk++; if (pc !== 32'h3F4) begin n_fail++; $display("FAIL after_branch_seq got=%h exp=%h", pc, 32'h3F4); end
    goto(32'h503);
    n_chk++; if (pc !== 32'h500) begin n_fail++; $display("FAIL jump_align got=%h exp=%h", pc, 32'h500); end
  endtask

  task automatic test_stall_exc();
    logic [31:0] exp_seq [3];
    exp_seq = '{32'd300, 32'd300, 32'h80};
    goto(32'd300);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      exc = (i == 2);
      tick();
      n_chk++; if (pc !== exp_seq[i]) begin n_fail++; $display("FAIL stall_exc[%0d] got=%h exp=%h", i, pc, exp_seq[i]); end
    end
    clear_ctl();
    tick();
    n_chk++; if (pc !== 32'h84) begin n_fail++; $display("FAIL after_exc got=%h exp=%h", pc, 32'h84); end
  endtask

  task automatic test_priority();
    stall = 1; jr = 1; jr_target = 32'h700; jump = 1; jump_target = 32'h500;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'h84) begin n_fail++; $display("FAIL stall_over_jr got=%h exp=%h", pc, 32'h84); end
    jr = 1; jr_target = 32'h703; jump = 1; jump_target = 32'h500; branch_taken = 1; branch_target = 32'h3F0;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'h700) begin n_fail++; $display("FAIL jr_over_jump got=%h exp=%h", pc, 32'h700); end
    exc = 1; jr = 1; jr_target = 32'h900;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'h80) begin n_fail++; $display("FAIL exc_over_jr got=%h exp=%h", pc, 32'h80); end
    run = 0; exc = 1;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'd100) begin n_fail++; $display("FAIL halt_over_exc got=%h exp=%h", pc, 32'd100); end
    n_chk++; if (running !== 1'b0) begin n_fail++; $display("FAIL halt_running got=%b exp=0", running); end
  endtask

  task automatic test_halt();
    jump = 1; jump_target = 32'h500;
    tick(); tick(); clear_ctl();
    n_chk++; if (pc !== 32'd100) begin n_fail++; $display("FAIL halt_hold got=%h exp=%h", pc, 32'd100); end
    n_chk++; if (pc_plus4 !== 32'd104) begin n_fail++; $display("FAIL halt_plus4 got=%h exp=%h", pc_plus4, 32'd104); end
    run = 1;
    tick();
    n_chk++; if (pc !== 32'd100 || running !== 1'b1) begin n_fail++; $display("FAIL restart pc=%h run=%b exp=%h/1", pc, running, 32'd100); end
    tick();
    n_chk++; if (pc !== 32'd104) begin n_fail++; $display("FAIL restart_adv got=%h exp=%h", pc, 32'd104); end
  endtask

  task automatic test_ret_plain();
    jr = 1; ret = 1; jr_target = 32'h900;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'h900) begin n_fail++; $display("FAIL ret_empty_pc got=%h exp=%h", pc, 32'h900); end
`ifdef PC_RAS_EN
    n_chk++; if (ras_underflow !== 1'b1) begin n_fail++; $display("FAIL ret_empty_uflow got=%b exp=1", ras_underflow); end
`else
    n_chk++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL ret_plain_uflow got=%b exp=0", ras_underflow); end
    goto(32'h100);
    jump = 1; call = 1; jump_target = 32'h400;
    tick(); clear_ctl();
    jr = 1; ret = 1; jr_target = 32'h904;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'h904) begin n_fail++; $display("FAIL ret_no_stack got=%h exp=%h", pc, 32'h904); end
`endif
    tick();
    n_chk++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL uflow_clear got=%b exp=0", ras_underflow); end
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras_basic();
    logic [31:0] exp_ret [2];
    exp_ret = '{32'h204, 32'h104};
    goto(32'h100); jump = 1; call = 1; jump_target = 32'h400; tick(); clear_ctl();
    goto(32'h200); jump = 1; call = 1; jump_target = 32'h600; tick(); clear_ctl();
    for (int i = 0; i < 2; i++) begin
      jr = 1; ret = 1; jr_target = 32'h999;
      tick(); clear_ctl();
      n_chk++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ras_pop[%0d] got=%h exp=%h", i, pc, exp_ret[i]); end
    end
    jr = 1; ret = 1; jr_target = 32'h900;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'h900 || ras_underflow !== 1'b1) begin n_fail++; $display("FAIL ras_uflow pc=%h uf=%b exp=%h/1", pc, ras_underflow, 32'h900); end
    tick();
    n_chk++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL ras_uflow_pulse got=%b exp=0", ras_underflow); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h1404, 32'h1304, 32'h1204, 32'h1104};
    for (int k = 0; k < 5; k++) begin
      goto(32'h1000 + 32'(k) * 32'h100);
      jump = 1; call = 1; jump_target = 32'h4000;
      tick(); clear_ctl();
    end
    for (int i = 0; i < 4; i++) begin
      jr = 1; ret = 1; jr_target = 32'h999;
      tick(); clear_ctl();
      n_chk++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ras_ovf_pop[%0d] got=%h exp=%h", i, pc, exp_ret[i]); end
    end
    jr = 1; ret = 1; jr_target = 32'h908;
    tick(); clear_ctl();
    n_chk++; if (pc !== 32'h908 || ras_underflow !== 1'b1) begin n_fail++; $display("FAIL ras_ovf_uflow pc=%h uf=%b exp=%h/1", pc, ras_underflow, 32'h908); end
  endtask
`endif

  task automatic test_rst_mid_stall();
    stall = 1; jump = 1; call = 1; jump_target = 32'h500; rst = 1;
    tick(); clear_ctl(); rst = 0;
    n_chk++; if (pc !== 32'd100 || running !== 1'b0) begin n_fail++; $display("FAIL rst_mid pc=%h run=%b exp=%h/0", pc, running, 32'd100); end
    tick();
    n_chk++; if (pc !== 32'd100 || running !== 1'b1) begin n_fail++; $display("FAIL rst_restart pc=%h run=%b exp=%h/1", pc, running, 32'd100); end
  endtask

  task automatic test_wrap8();
    rst8 = 1; run8 = 1;
    tick();
    rst8 = 0;
    tick();
    n_chk++; if (pc8 !== 8'h64 || running8 !== 1'b1) begin n_fail++; $display("FAIL w8_start pc=%h run=%b exp=64/1", pc8, running8); end
    jump8 = 1; jump_target8 = 8'hFC;
    tick(); jump8 = 0;
    n_chk++; if (pc8 !== 8'hFC) begin n_fail++; $display("FAIL w8_jump got=%h exp=fc", pc8); end
    n_chk++; if (pc_plus4_8 !== 8'h00) begin n_fail++; $display("FAIL w8_plus4 got=%h exp=00", pc_plus4_8); end
    tick();
    n_chk++; if (pc8 !== 8'h00) begin n_fail++; $display("FAIL w8_wrap got=%h exp=00", pc8); end
    run8 = 0;
    tick();
    n_chk++; if (pc8 !== 8'h64 || running8 !== 1'b0) begin n_fail++; $display("FAIL w8_halt pc=%h run=%b exp=64/0", pc8, running8); end
    n_chk++; if (ras_underflow8 !== 1'b0) begin n_fail++; $display("FAIL w8_uflow got=%b exp=0", ras_underflow8); end
  endtask

  initial begin
    rst8 = 1; run8 = 0; jump8 = 0; jump_target8 = '0;
    clear_ctl();
    test_reset();
    test_startup();
    test_jump_branch();
    test_stall_exc();
    test_priority();
    test_halt();
    test_ret_plain();
`ifdef PC_RAS_EN
    test_ras_basic();
    test_ras_overflow();
`endif
    test_rst_mid_stall();
    test_wrap8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
